// File: rtl/fetch_byte_queue_pkg.sv
// Shared constants and types for the instruction prefetch queue and its address unit.
// Reset CS:IP is also pre-resolved to a physical address here for the reset value of adr_o.
package fetch_byte_queue_pkg;

  localparam int          DEPTH    = 6;
  localparam logic [15:0] RST_CS   = 16'hFFFF;
  localparam logic [15:0] RST_IP   = 16'h0000;
  localparam int          CNT_W    = $clog2(DEPTH + 1);
  localparam logic [19:0] RST_PHYS = {RST_CS, 4'h0} + {4'h0, RST_IP};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] cs;
    logic [15:0] ip;
  } seg_ptr_t;

endpackage

// File: rtl/fetch_byte_queue_if.sv
// Bus, decoder and jump signals of the prefetch queue.
// master = the queue itself, slave = memory bus / decoder / jump logic side.
interface fetch_byte_queue_if;
  import fetch_byte_queue_pkg::*;

  logic             flush;
  logic [15:0]      flush_cs;
  logic [15:0]      flush_ip;
  logic             req_o;
  logic [18:0]      adr_o;
  logic [15:0]      dat_i;
  logic             ack_i;
  logic [1:0]       consume;
  logic [15:0]      dout;
  logic [CNT_W-1:0] count;
  logic [15:0]      ip_o;

  modport master (
    input  flush, flush_cs, flush_ip, dat_i, ack_i, consume,
    output req_o, adr_o, dout, count, ip_o
  );

  modport slave (
    output flush, flush_cs, flush_ip, dat_i, ack_i, consume,
    input  req_o, adr_o, dout, count, ip_o
  );

endinterface

// File: rtl/fetch_seg_adder.sv
// Combinational real-mode address: seg*16 + off, wrapped to 20 bits.
// Split into word address and byte lane so data-side users can pick the lane.
module fetch_seg_adder (
  input  logic [15:0] seg,
  input  logic [15:0] off,
  output logic [18:0] adr,
  output logic        lane
);

  logic [19:0] phys;

  assign phys = {seg, 4'h0} + {4'h0, off};
  assign adr  = phys[19:1];
  assign lane = phys[0];

endmodule

// File: rtl/fetch_byte_queue.sv
// Byte prefetch queue: word fetches from CS:IP, little-endian append, 0..2 byte consume per cycle.
// Fetched data appears one cycle after ack; a flush during an open bus cycle drops that cycle's data.
module fetch_byte_queue (
  input  logic               clk,
  input  logic               rst,
  fetch_byte_queue_if.master bus
);
  import fetch_byte_queue_pkg::*;

  fetch_state_t     state, state_n;
  seg_ptr_t         fptr, fptr_n;
  logic [15:0]      ip, ip_n;
  logic [7:0]       q   [DEPTH];
  logic [7:0]       q_n [DEPTH];
  logic [CNT_W-1:0] count, count_n;
  logic [CNT_W-1:0] removed, written, base, width;
  logic             drop, drop_n;
  logic             req, hold, take, space_ok;
  logic [18:0]      adr_q, adr_n;
  logic             lane_q, lane_n;

  // lane_q mirrors fetch ip bit 0: odd offsets only deliver the high byte
  assign width    = lane_q ? CNT_W'(1) : CNT_W'(2);
  assign space_ok = (CNT_W'(DEPTH) - count) >= width;
  assign removed  = (CNT_W'(bus.consume) > count) ? count : CNT_W'(bus.consume);
  assign take     = req && bus.ack_i && !drop && !bus.flush;
  assign written  = take ? width : '0;
  assign base     = count - removed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // A flush in IDLE holds off the next request so the new address gets its idle cycle
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (!bus.flush && space_ok) state_n = ST_REQ;
      ST_REQ:  if (bus.ack_i)              state_n = ST_IDLE;
      default:                             state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    req  = (state == ST_REQ);
    hold = (state == ST_REQ) && !bus.ack_i;
  end

  always_comb begin
    fptr_n  = fptr;
    ip_n    = ip;
    count_n = count;
    drop_n  = drop;
    for (int i = 0; i < DEPTH; i++) begin
      q_n[i] = q[i];
    end
    if (bus.flush) begin
      fptr_n  = '{cs: bus.flush_cs, ip: bus.flush_ip};
      ip_n    = bus.flush_ip;
      count_n = '0;
      drop_n  = hold;
      for (int i = 0; i < DEPTH; i++) begin
        q_n[i] = 8'h00;
      end
    end else begin
      ip_n    = ip + 16'(removed);
      count_n = count - removed + written;
      if (req && bus.ack_i) begin
        drop_n = 1'b0;
      end
      if (take) begin
        fptr_n.ip = fptr.ip + 16'(width);
      end
      // Shift out consumed bytes (zero fill keeps empty slots reading 0), then append at the tail
      for (int i = 0; i < DEPTH; i++) begin
        q_n[i] = (i + int'(removed) < DEPTH) ? q[i + int'(removed)] : 8'h00;
        if (take && CNT_W'(i) == base) begin
          q_n[i] = lane_q ? bus.dat_i[15:8] : bus.dat_i[7:0];
        end
        if (take && !lane_q && CNT_W'(i) == base + CNT_W'(1)) begin
          q_n[i] = bus.dat_i[15:8];
        end
      end
    end
  end

  fetch_seg_adder u_adr (
    .seg  (fptr_n.cs),
    .off  (fptr_n.ip),
    .adr  (adr_n),
    .lane (lane_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fptr   <= '{cs: RST_CS, ip: RST_IP};
      ip     <= RST_IP;
      count  <= '0;
      drop   <= 1'b0;
      adr_q  <= RST_PHYS[19:1];
      lane_q <= RST_PHYS[0];
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= 8'h00;
      end
    end else begin
      fptr  <= fptr_n;
      ip    <= ip_n;
      count <= count_n;
      drop  <= drop_n;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= q_n[i];
      end
      // Address stays frozen while a bus cycle is open, even across a flush
      if (!hold) begin
        adr_q  <= adr_n;
        lane_q <= lane_n;
      end
    end
  end

  assign bus.req_o = req;
  assign bus.adr_o = adr_q;
  assign bus.dout  = {q[1], q[0]};
  assign bus.count = count;
  assign bus.ip_o  = ip;

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Bench for fetch_byte_queue: directed scenarios plus a randomized run against a byte-queue model.
module tb_fetch_byte_queue;

  localparam int QD = 6;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fetch_byte_queue_if bus ();

  fetch_byte_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  mq[$];
  logic [15:0] m_cs, m_fip, m_ip;
  logic [18:0] m_lat;
  bit          m_req, m_drop;

  function automatic logic [18:0] mphys(input logic [15:0] cs, input logic [15:0] off);
    logic [19:0] p;
    p = 20'(cs) * 20'd16 + 20'(off);
    return p[19:1];
  endfunction

  function automatic logic [15:0] exp_dout();
    logic [7:0] b0, b1;
    b0 = (mq.size() > 0) ? mq[0] : 8'h00;
    b1 = (mq.size() > 1) ? mq[1] : 8'h00;
    return {b1, b0};
  endfunction

  function automatic logic [18:0] exp_adr();
    return m_req ? m_lat : mphys(m_cs, m_fip);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cs   = 16'hFFFF;
    m_fip  = 16'h0000;
    m_ip   = 16'h0000;
    m_req  = 1'b0;
    m_drop = 1'b0;
    m_lat  = 19'h0;
  endtask

  // Drive one cycle of inputs, advance the model, and land 1 time unit after the clock edge
  task automatic step(input logic f, input logic [15:0] fcs, input logic [15:0] fip,
                      input logic a, input logic [15:0] d, input logic [1:0] c);
    int free, w, rem;
    bit req_n;
    bus.flush    = f;
    bus.flush_cs = fcs;
    bus.flush_ip = fip;
    bus.ack_i    = a;
    bus.dat_i    = d;
    bus.consume  = c;
    free  = QD - mq.size();
    w     = m_fip[0] ? 1 : 2;
    rem   = (int'(c) < mq.size()) ? int'(c) : mq.size();
    req_n = m_req ? !a : (!f && free >= w);
    if (f) begin
      mq.delete();
      m_cs   = fcs;
      m_fip  = fip;
      m_ip   = fip;
      m_drop = m_req && !a;
    end else begin
      m_ip = m_ip + 16'(rem);
      repeat (rem) void'(mq.pop_front());
      if (m_req && a) begin
        if (!m_drop) begin
          if (w == 2) mq.push_back(d[7:0]);
          mq.push_back(d[15:8]);
          m_fip = m_fip + 16'(w);
        end
        m_drop = 1'b0;
      end
    end
    if (!m_req && req_n) m_lat = mphys(m_cs, m_fip);
    m_req = req_n;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.req_o !== 1'b0)      begin errors++; $display("FAIL rst_req got=%b want=0", bus.req_o); end
    checks++; if (bus.count !== 3'd0)      begin errors++; $display("FAIL rst_count got=%0d want=0", bus.count); end
    checks++; if (bus.dout !== 16'h0000)   begin errors++; $display("FAIL rst_dout got=%h want=0000", bus.dout); end
    checks++; if (bus.adr_o !== 19'h7FFF8) begin errors++; $display("FAIL rst_adr got=%h want=7fff8", bus.adr_o); end
    checks++; if (bus.ip_o !== 16'h0000)   begin errors++; $display("FAIL rst_ip got=%h want=0000", bus.ip_o); end
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    checks++; if (bus.req_o !== 1'b1)      begin errors++; $display("FAIL first_req got=%b want=1", bus.req_o); end
    checks++; if (bus.adr_o !== 19'h7FFF8) begin errors++; $display("FAIL first_adr got=%h want=7fff8", bus.adr_o); end
    checks++; if (bus.count !== 3'd0)      begin errors++; $display("FAIL first_count got=%0d want=0", bus.count); end
  endtask

  task automatic test_fill();
    step(0, 0, 0, 1, 16'h1234, 0);
    checks++; if (bus.count !== 3'd2)      begin errors++; $display("FAIL fill_count1 got=%0d want=2", bus.count); end
    checks++; if (bus.req_o !== 1'b0)      begin errors++; $display("FAIL fill_gap got=%b want=0", bus.req_o); end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'h5678, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'h9ABC, 0);
    step(0, 0, 0, 0, 0, 0);
    checks++; if (bus.count !== 3'd6)      begin errors++; $display("FAIL fill_count got=%0d want=6", bus.count); end
    checks++; if (bus.dout !== 16'h1234)   begin errors++; $display("FAIL fill_dout got=%h want=1234", bus.dout); end
    checks++; if (bus.req_o !== 1'b0)      begin errors++; $display("FAIL fill_full_req got=%b want=0", bus.req_o); end
  endtask

  task automatic test_odd_flush();
    step(1, 16'h1000, 16'h0003, 0, 0, 0);
    checks++; if (bus.count !== 3'd0)      begin errors++; $display("FAIL odd_flush_count got=%0d want=0", bus.count); end
    checks++; if (bus.adr_o !== 19'h08001) begin errors++; $display("FAIL odd_flush_adr got=%h want=08001", bus.adr_o); end
    step(0, 0, 0, 0, 0, 0);
    checks++; if (bus.req_o !== 1'b1)      begin errors++; $display("FAIL odd_req got=%b want=1", bus.req_o); end
    step(0, 0, 0, 1, 16'hAABB, 0);
    checks++; if (bus.count !== 3'd1)      begin errors++; $display("FAIL odd_count got=%0d want=1", bus.count); end
    checks++; if (bus.dout !== 16'h00AA)   begin errors++; $display("FAIL odd_dout got=%h want=00aa", bus.dout); end
    checks++; if (bus.adr_o !== 19'h08002) begin errors++; $display("FAIL odd_next_adr got=%h want=08002", bus.adr_o); end
    checks++; if (bus.ip_o !== 16'h0003)   begin errors++; $display("FAIL odd_ip got=%h want=0003", bus.ip_o); end
  endtask

  task automatic test_simul();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'h1122, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'h3344, 1);
    step(0, 0, 0, 0, 0, 0);
    checks++; if (bus.count !== 3'd4)      begin errors++; $display("FAIL simul_pre_count got=%0d want=4", bus.count); end
    checks++; if (bus.req_o !== 1'b1)      begin errors++; $display("FAIL simul_pre_req got=%b want=1", bus.req_o); end
    step(0, 0, 0, 1, 16'h5566, 2);
    checks++; if (bus.count !== 3'd4)      begin errors++; $display("FAIL simul_count got=%0d want=4", bus.count); end
    checks++; if (bus.ip_o !== 16'h0006)   begin errors++; $display("FAIL simul_ip got=%h want=0006", bus.ip_o); end
    checks++; if (bus.dout !== 16'h3344)   begin errors++; $display("FAIL simul_dout got=%h want=3344", bus.dout); end
    step(0, 0, 0, 0, 0, 2);
    checks++; if (bus.dout !== 16'h5566)   begin errors++; $display("FAIL simul_tail got=%h want=5566", bus.dout); end
    checks++; if (bus.dout !== exp_dout()) begin errors++; $display("FAIL simul_model got=%h want=%h", bus.dout, exp_dout()); end
  endtask

  task automatic test_flush_drop();
    for (int k = 0; k < 8 && bus.req_o !== 1'b1; k++) step(0, 0, 0, 0, 0, 0);
    checks++; if (bus.req_o !== 1'b1)      begin errors++; $display("FAIL drop_wait_req got=%b want=1", bus.req_o); end
    step(1, 16'h2000, 16'h0100, 0, 0, 0);
    checks++; if (bus.req_o !== 1'b1)      begin errors++; $display("FAIL drop_hold_req got=%b want=1", bus.req_o); end
    checks++; if (bus.adr_o !== 19'h08005) begin errors++; $display("FAIL drop_hold_adr got=%h want=08005", bus.adr_o); end
    checks++; if (bus.count !== 3'd0)      begin errors++; $display("FAIL drop_flush_count got=%0d want=0", bus.count); end
    checks++; if (bus.ip_o !== 16'h0100)   begin errors++; $display("FAIL drop_ip got=%h want=0100", bus.ip_o); end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'hDEAD, 0);
    checks++; if (bus.count !== 3'd0)      begin errors++; $display("FAIL drop_count got=%0d want=0", bus.count); end
    checks++; if (bus.dout !== 16'h0000)   begin errors++; $display("FAIL drop_dout got=%h want=0000", bus.dout); end
    checks++; if (bus.req_o !== 1'b0)      begin errors++; $display("FAIL drop_idle got=%b want=0", bus.req_o); end
    step(0, 0, 0, 0, 0, 0);
    checks++; if (bus.req_o !== 1'b1)      begin errors++; $display("FAIL drop_new_req got=%b want=1", bus.req_o); end
    checks++; if (bus.adr_o !== 19'h10080) begin errors++; $display("FAIL drop_new_adr got=%h want=10080", bus.adr_o); end
  endtask

  task automatic test_wrap_clamp();
    step(0, 0, 0, 1, 16'h0102, 0);
    step(1, 16'h0000, 16'hFFFE, 0, 0, 0);
    checks++; if (bus.adr_o !== 19'h07FFF) begin errors++; $display("FAIL wrap_adr got=%h want=07fff", bus.adr_o); end
    step(0, 0, 0, 0, 0, 0);
    checks++; if (bus.req_o !== 1'b1)      begin errors++; $display("FAIL wrap_req got=%b want=1", bus.req_o); end
    step(0, 0, 0, 1, 16'hBEEF, 0);
    checks++; if (bus.adr_o !== 19'h00000) begin errors++; $display("FAIL wrap_next_adr got=%h want=00000", bus.adr_o); end
    checks++; if (bus.dout !== 16'hBEEF)   begin errors++; $display("FAIL wrap_dout got=%h want=beef", bus.dout); end
    checks++; if (bus.ip_o !== 16'hFFFE)   begin errors++; $display("FAIL wrap_ip got=%h want=fffe", bus.ip_o); end
    step(0, 0, 0, 0, 0, 1);
    checks++; if (bus.count !== 3'd1)      begin errors++; $display("FAIL clamp_pre_count got=%0d want=1", bus.count); end
    step(0, 0, 0, 0, 0, 2);
    checks++; if (bus.count !== 3'd0)      begin errors++; $display("FAIL clamp_count got=%0d want=0", bus.count); end
    checks++; if (bus.ip_o !== 16'h0000)   begin errors++; $display("FAIL clamp_ip got=%h want=0000", bus.ip_o); end
  endtask

  task automatic test_random();
    logic        f, a;
    logic [15:0] fcs, fip, d;
    logic [1:0]  c;
    for (int n = 0; n < 600; n++) begin
      f   = ($urandom_range(0, 19) == 0);
      fcs = 16'($urandom);
      fip = 16'($urandom);
      a   = (bus.req_o === 1'b1) && ($urandom_range(0, 2) != 0);
      d   = 16'($urandom);
      c   = ($urandom_range(0, 3) == 3) ? 2'd0 : 2'($urandom_range(0, 2));
      step(f, fcs, fip, a, d, c);
      checks++; if (bus.count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, bus.count, mq.size()); end
      checks++; if (bus.dout !== exp_dout())     begin errors++; $display("FAIL rnd_dout n=%0d got=%h want=%h", n, bus.dout, exp_dout()); end
      checks++; if (bus.ip_o !== m_ip)           begin errors++; $display("FAIL rnd_ip n=%0d got=%h want=%h", n, bus.ip_o, m_ip); end
      checks++; if (bus.req_o !== m_req)         begin errors++; $display("FAIL rnd_req n=%0d got=%b want=%b", n, bus.req_o, m_req); end
      checks++; if (bus.adr_o !== exp_adr())     begin errors++; $display("FAIL rnd_adr n=%0d got=%h want=%h", n, bus.adr_o, exp_adr()); end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.flush_cs = 16'h0;
    bus.flush_ip = 16'h0;
    bus.ack_i    = 1'b0;
    bus.dat_i    = 16'h0;
    bus.consume  = 2'd0;
    test_reset();
    test_fill();
    test_odd_flush();
    test_simul();
    test_flush_drop();
    test_wrap_clamp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
